// File: rtl/vtgen_prog_if.sv
// rtl/vtgen_prog_if.sv - configuration and video signal bundle for the raster timing generator
interface vtgen_prog_if #(
    parameter int HW = 11,
    parameter int VW = 10
);
    logic          en;
    logic          cfg_wr;
    logic [HW-1:0] cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act;
    logic [VW-1:0] cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act;
    logic          cfg_pend;
    logic          cfg_err;
    logic          hs, vs, de;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output en, cfg_wr,
        output cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act,
        output cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act,
        input  cfg_pend, cfg_err, hs, vs, de, x, y, line_start, frame_start
    );

    modport slave (
        input  en, cfg_wr,
        input  cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act,
        input  cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act,
        output cfg_pend, cfg_err, hs, vs, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vtgen_prog.sv
// rtl/vtgen_prog.sv - programmable raster timing generator with frame-boundary reconfiguration
module vtgen_prog #(
    parameter int HW      = 11,
    parameter int VW      = 10,
    parameter int H_TOTAL = 459,
    parameter int H_SYNC  = 10,
    parameter int H_BP    = 42,
    parameter int H_ACT   = 320,
    parameter int V_TOTAL = 292,
    parameter int V_SYNC  = 3,
    parameter int V_BP    = 6,
    parameter int V_ACT   = 196,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter bit DE_POL  = 1'b1
) (
    input  logic        clk,
    input  logic        xrst,
    vtgen_prog_if.slave bus
);
    typedef struct packed {
        logic [HW-1:0] ht, hs, hb, ha;
        logic [VW-1:0] vt, vs, vb, va;
    } tcfg_t;

    localparam tcfg_t CFG_RST = {HW'(H_TOTAL), HW'(H_SYNC), HW'(H_BP), HW'(H_ACT),
                                 VW'(V_TOTAL), VW'(V_SYNC), VW'(V_BP), VW'(V_ACT)};

    tcfg_t         act_q, act_d, shd_q, shd_d, wcfg;
    logic          pend_q, pend_d, err_q, err_d;
    logic [HW-1:0] h_q, h_d, x_q, x_d;
    logic [VW-1:0] v_q, v_d, y_q, y_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
    logic          wr_ok, h_last, v_last, apply, hde, vde;
    logic [HW:0]   h_sum, h_end;
    logic [VW:0]   v_sum, v_end;

    // Sums are one bit wider so an extreme back porch cannot wrap into range.
    always_comb begin
        wcfg  = {bus.cfg_h_total, bus.cfg_h_sync, bus.cfg_h_bp, bus.cfg_h_act,
                 bus.cfg_v_total, bus.cfg_v_sync, bus.cfg_v_bp, bus.cfg_v_act};
        h_sum = {1'b0, wcfg.hb} + {1'b0, wcfg.ha};
        v_sum = {1'b0, wcfg.vb} + {1'b0, wcfg.va};
        wr_ok = !((wcfg.ht < HW'(2)) || (wcfg.vt < VW'(2)) ||
                  (wcfg.hs == '0) || (wcfg.hs >= wcfg.ht) ||
                  (wcfg.vs == '0) || (wcfg.vs >= wcfg.vt) ||
                  (wcfg.ha == '0) || (h_sum > {1'b0, wcfg.ht}) ||
                  (wcfg.va == '0) || (v_sum > {1'b0, wcfg.vt}));
    end

    always_comb begin
        h_last = (h_q == act_q.ht - HW'(1));
        v_last = (v_q == act_q.vt - VW'(1));
        apply  = !bus.en || (h_last && v_last);
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        err_d  = bus.cfg_wr && !wr_ok;
        if (apply) begin
            // A write landing on the boundary bypasses the shadow entirely.
            if (bus.cfg_wr && wr_ok) begin
                act_d = wcfg;
            end else if (pend_q) begin
                act_d = shd_q;
            end
            pend_d = 1'b0;
        end else if (bus.cfg_wr && wr_ok) begin
            shd_d  = wcfg;
            pend_d = 1'b1;
        end
        h_d = '0;
        v_d = '0;
        if (bus.en && !h_last) begin
            h_d = h_q + HW'(1);
            v_d = v_q;
        end else if (bus.en && !v_last) begin
            v_d = v_q + VW'(1);
        end
    end

    always_comb begin
        h_end = {1'b0, act_q.hb} + {1'b0, act_q.ha};
        v_end = {1'b0, act_q.vb} + {1'b0, act_q.va};
        hde   = (h_q >= act_q.hb) && ({1'b0, h_q} < h_end);
        vde   = (v_q >= act_q.vb) && ({1'b0, v_q} < v_end);
        hs_d  = ~HS_POL;
        vs_d  = ~VS_POL;
        de_d  = ~DE_POL;
        x_d   = '0;
        y_d   = '0;
        ls_d  = 1'b0;
        fs_d  = 1'b0;
        if (bus.en) begin
            hs_d = (h_q < act_q.hs) ? HS_POL : ~HS_POL;
            vs_d = (v_q < act_q.vs) ? VS_POL : ~VS_POL;
            de_d = (hde && vde) ? DE_POL : ~DE_POL;
            x_d  = (hde && vde) ? h_q - act_q.hb : '0;
            y_d  = vde ? v_q - act_q.vb : '0;
            ls_d = (h_q == '0);
            fs_d = (h_q == '0) && (v_q == '0);
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            act_q  <= CFG_RST;
            shd_q  <= CFG_RST;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= ~DE_POL;
            x_q    <= '0;
            y_q    <= '0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            err_q  <= err_d;
            h_q    <= h_d;
            v_q    <= v_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            x_q    <= x_d;
            y_q    <= y_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    assign bus.cfg_pend    = pend_q;
    assign bus.cfg_err     = err_q;
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.de          = de_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;
endmodule
